debug_dump_tx: RTL and testbench

Transmit-side dump sequencer of the debug path: when the debug FSM requests a dump, it walks PC, cycle count, the 32 MIPS registers and the data memory. It serialises each 32-bit word into four 8-bit UART frames through the UART transmitter's start/done handshake. It is the counterpart of the receive path that assembles incoming bytes into 32-bit instruction words, and sits between the debug unit, the MIPS debug read ports and the UART TX.

---
 rtl/debug_dump_tx_pkg.sv | 42 ++++
 rtl/debug_dump_tx_word_to_bytes_tx.sv | 77 +++++++
 rtl/debug_dump_tx.sv | 153 +++++++++++++++
 tb/tb_debug_dump_tx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_dump_tx_pkg.sv
// Shared types and sizing helpers for the debug dump transmit path.
package debug_dump_tx_pkg;

  typedef enum logic [1:0] {
    SEC_PC,
    SEC_CYC,
    SEC_REG,
    SEC_MEM
  } section_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CAPT,
    ST_XMIT,
    ST_NEXT,
    ST_DONE
  } dump_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_WAIT
  } tx_state_e;

  localparam int unsigned DEF_BITS_SIZE     = 32;
  localparam int unsigned DEF_SIZE_TRAMA    = 8;
  localparam int unsigned DEF_N_REGISTERS   = 32;
  localparam int unsigned DEF_SIZE_MEM_DATA = 16;

  function automatic int unsigned dump_words(input int unsigned n_regs, input int unsigned n_mem);
    return 2 + n_regs + n_mem;
  endfunction

  function automatic int unsigned bytes_per_word(input int unsigned bits, input int unsigned frame);
    return bits / frame;
  endfunction

  localparam int unsigned DUMP_WORDS     = dump_words(DEF_N_REGISTERS, DEF_SIZE_MEM_DATA);
  localparam int unsigned BYTES_PER_WORD = bytes_per_word(DEF_BITS_SIZE, DEF_SIZE_TRAMA);

endpackage

// File: rtl/debug_dump_tx_word_to_bytes_tx.sv
// Serialises one captured word into UART frames, low byte first, using the
// transmitter's start/done handshake.
module word_to_bytes_tx
  import debug_dump_tx_pkg::*;
#(
  parameter int unsigned BITS_SIZE  = DEF_BITS_SIZE,
  parameter int unsigned SIZE_TRAMA = DEF_SIZE_TRAMA
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic [BITS_SIZE-1:0]  word_i,
  input  logic                  tx_done_i,
  output logic                  start_o,
  output logic [SIZE_TRAMA-1:0] data_o,
  output logic                  word_done_o
);

  localparam int unsigned BYTES = bytes_per_word(BITS_SIZE, SIZE_TRAMA);
  localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  tx_state_e            state_q, state_d;
  logic [BITS_SIZE-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;

  // State, shift register and byte counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= TX_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Load, one-cycle start pulse, then wait for done; shift only between bytes
  // so the last byte stays on the data lines after the word completes.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    start_o     = 1'b0;
    word_done_o = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (load_i) begin
          shreg_d = word_i;
          cnt_d   = '0;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        start_o = 1'b1;
        state_d = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_done_i) begin
          if (cnt_q == CNT_W'(BYTES - 1)) begin
            word_done_o = 1'b1;
            state_d     = TX_IDLE;
          end else begin
            shreg_d = shreg_q >> SIZE_TRAMA;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = TX_SEND;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign data_o = shreg_q[SIZE_TRAMA-1:0];

endmodule

// File: rtl/debug_dump_tx.sv
// Dump sequencer: walks PC, cycle count, register file and data memory and
// hands each word to the byte serialiser.
module debug_dump_tx
  import debug_dump_tx_pkg::*;
#(
  parameter int unsigned BITS_SIZE     = DEF_BITS_SIZE,
  parameter int unsigned SIZE_TRAMA    = DEF_SIZE_TRAMA,
  parameter int unsigned N_REGISTERS   = DEF_N_REGISTERS,
  parameter int unsigned SIZE_MEM_DATA = DEF_SIZE_MEM_DATA
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic [BITS_SIZE-1:0]           i_mips_pc,
  input  logic [BITS_SIZE-1:0]           i_clk_wiz_count,
  input  logic [BITS_SIZE-1:0]           i_data_bankregisters,
  input  logic [BITS_SIZE-1:0]           i_data_mem,
  input  logic                           i_uart_tx_done,
  output logic [$clog2(N_REGISTERS)-1:0] o_select_addr_registers,
  output logic [BITS_SIZE-1:0]           o_select_addr_memdata,
  output logic                           o_flag_tx_ready,
  output logic [SIZE_TRAMA-1:0]          o_uart_tx_data,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int unsigned REG_AW = $clog2(N_REGISTERS);
  localparam int unsigned IDX_W  = $clog2((N_REGISTERS > SIZE_MEM_DATA) ? N_REGISTERS : SIZE_MEM_DATA);
  localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(N_REGISTERS - 1);
  localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(SIZE_MEM_DATA - 1);

  dump_state_e          state_q, state_d;
  section_e             sec_q, sec_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [REG_AW-1:0]    reg_addr_q, reg_addr_d;
  logic [BITS_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [IDX_W-1:0]     idx_inc;
  logic [BITS_SIZE-1:0] cap_word;
  logic                 load;
  logic                 word_done;

  assign idx_inc = idx_q + IDX_W'(1);

  // Sequencer state, section/index counters and held select addresses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      sec_q      <= SEC_PC;
      idx_q      <= '0;
      reg_addr_q <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      idx_q      <= idx_d;
      reg_addr_q <= reg_addr_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Next state; select addresses are updated on the NEXT->ADDR transition so
  // they are valid throughout ADDR, giving the read ports one cycle of latency.
  always_comb begin
    state_d    = state_q;
    sec_d      = sec_q;
    idx_d      = idx_q;
    reg_addr_d = reg_addr_q;
    mem_addr_d = mem_addr_q;
    load       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          sec_d   = SEC_PC;
          idx_d   = '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: state_d = ST_CAPT;
      ST_CAPT: begin
        load    = 1'b1;
        state_d = ST_XMIT;
      end
      ST_XMIT: begin
        if (word_done) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        state_d = ST_ADDR;
        unique case (sec_q)
          SEC_PC: begin
            sec_d = SEC_CYC;
            idx_d = '0;
          end
          SEC_CYC: begin
            sec_d      = SEC_REG;
            idx_d      = '0;
            reg_addr_d = '0;
          end
          SEC_REG: begin
            if (idx_q == REG_LAST) begin
              sec_d      = SEC_MEM;
              idx_d      = '0;
              mem_addr_d = '0;
            end else begin
              idx_d      = idx_inc;
              reg_addr_d = idx_inc[REG_AW-1:0];
            end
          end
          SEC_MEM: begin
            if (idx_q == MEM_LAST) begin
              state_d = ST_DONE;
            end else begin
              idx_d      = idx_inc;
              mem_addr_d = BITS_SIZE'(idx_inc);
            end
          end
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Source word for the current section, sampled by the serialiser in CAPT.
  always_comb begin
    cap_word = '0;
    unique case (sec_q)
      SEC_PC:  cap_word = i_mips_pc;
      SEC_CYC: cap_word = i_clk_wiz_count;
      SEC_REG: cap_word = i_data_bankregisters;
      SEC_MEM: cap_word = i_data_mem;
    endcase
  end

  word_to_bytes_tx #(
    .BITS_SIZE (BITS_SIZE),
    .SIZE_TRAMA(SIZE_TRAMA)
  ) u_word_to_bytes_tx (
    .clk_i      (i_clk),
    .reset_i    (i_reset),
    .load_i     (load),
    .word_i     (cap_word),
    .tx_done_i  (i_uart_tx_done),
    .start_o    (o_flag_tx_ready),
    .data_o     (o_uart_tx_data),
    .word_done_o(word_done)
  );

  assign o_select_addr_registers = reg_addr_q;
  assign o_select_addr_memdata   = mem_addr_q;
  assign o_busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign o_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_debug_dump_tx.sv
// Bench for debug_dump_tx: frame-stream model plus directed scenarios.
module tb_debug_dump_tx;
  import debug_dump_tx_pkg::*;

  localparam int NREG   = 32;
  localparam int NMEM   = 16;
  localparam int FRAMES = int'(BYTES_PER_WORD * DUMP_WORDS);
  localparam int NEVER  = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_uart_tx_done;
  logic [31:0] i_mips_pc, i_clk_wiz_count, i_data_bankregisters, i_data_mem;
  logic [4:0]  o_select_addr_registers;
  logic [31:0] o_select_addr_memdata;
  logic        o_flag_tx_ready, o_busy, o_done;
  logic [7:0]  o_uart_tx_data;

  debug_dump_tx #(
    .BITS_SIZE(32), .SIZE_TRAMA(8), .N_REGISTERS(NREG), .SIZE_MEM_DATA(NMEM)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
    .i_mips_pc(i_mips_pc), .i_clk_wiz_count(i_clk_wiz_count),
    .i_data_bankregisters(i_data_bankregisters), .i_data_mem(i_data_mem),
    .i_uart_tx_done(i_uart_tx_done),
    .o_select_addr_registers(o_select_addr_registers),
    .o_select_addr_memdata(o_select_addr_memdata),
    .o_flag_tx_ready(o_flag_tx_ready), .o_uart_tx_data(o_uart_tx_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // Register file holds k at Rk, memory holds 0x100+k; both with one cycle of read latency.
  always @(posedge clk) begin
    i_data_bankregisters <= 32'(o_select_addr_registers);
    i_data_mem           <= 32'h100 + o_select_addr_memdata;
  end

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int f);
    int w;
    logic [31:0] word;
    w = f / 4;
    if (w == 0)            word = i_mips_pc;
    else if (w == 1)       word = i_clk_wiz_count;
    else if (w < 2 + NREG) word = 32'(w - 2);
    else                   word = 32'h100 + 32'(w - 2 - NREG);
    return word[8*(f%4) +: 8];
  endfunction

  // Model state, owned by the compare process.
  int         cyc_n = 0;
  bit         m_en = 0, rst_prev = 0, active = 0, pend = 0, in_wait = 0;
  int         exp_start = NEVER, exp_done = NEVER;
  int         frame_cnt = 0, done_cnt = 0, exp_reg = 0, exp_mem = 0;
  logic [7:0] last_byte = '0;
  logic [7:0] frames_log [FRAMES];
  int         flag_cyc [8];
  int         start_cyc = 0;

  // Per-cycle compare against the frame-stream model.
  always @(negedge clk) begin
    int w;
    cyc_n++;
    if (rst_prev) begin
      m_en = 1; active = 0; pend = 0; in_wait = 0;
      exp_start = NEVER; exp_done = NEVER; last_byte = '0;
      exp_reg = 0; exp_mem = 0;
      chk("reset_regaddr", 32'(o_select_addr_registers), 32'd0);
      chk("reset_memaddr", o_select_addr_memdata, 32'd0);
    end
    if (m_en) begin
      if (pend) begin active = 1; pend = 0; end
      if (cyc_n == exp_done) active = 0;
      chk("busy", 32'(o_busy), 32'(active));
      chk("done", 32'(o_done), 32'(cyc_n == exp_done));
      if (o_done === 1'b1) done_cnt++;
      chk("tx_ready", 32'(o_flag_tx_ready), 32'(active && cyc_n == exp_start));
      if (in_wait && i_uart_tx_done) begin
        in_wait = 0;
        if (frame_cnt % 4 != 0)     exp_start = cyc_n + 1;
        else if (frame_cnt == FRAMES) exp_done = cyc_n + 2;
        else                        exp_start = cyc_n + 4;
      end
      if (o_flag_tx_ready === 1'b1) begin
        w = frame_cnt / 4;
        if (w >= 2 && w < 2 + NREG) exp_reg = w - 2;
        else if (w >= 2 + NREG)     exp_mem = w - 2 - NREG;
        chk("frame_data", 32'(o_uart_tx_data), 32'(exp_byte(frame_cnt)));
        if (frame_cnt < FRAMES) frames_log[frame_cnt] = o_uart_tx_data;
        if (frame_cnt < 8) flag_cyc[frame_cnt] = cyc_n;
        last_byte = exp_byte(frame_cnt);
        frame_cnt++;
        in_wait = 1;
        exp_start = NEVER;
      end else begin
        chk("data_hold", 32'(o_uart_tx_data), 32'(last_byte));
      end
      if (o_flag_tx_ready === 1'b1 || in_wait) begin
        chk("regaddr", 32'(o_select_addr_registers), 32'(exp_reg));
        chk("memaddr", o_select_addr_memdata, 32'(exp_mem));
      end
      if (i_start && !active && !pend && cyc_n != exp_done && !i_reset) begin
        pend = 1; exp_start = cyc_n + 3; exp_done = NEVER;
        frame_cnt = 0; start_cyc = cyc_n;
      end
    end
    rst_prev = i_reset;
  end

  // UART responder: done 5 cycles after each start, with optional spurious
  // done in the start cycle and one long stall.
  int resp_cnt = 0, spur_at = -1, stall_at = -1;
  initial begin
    i_uart_tx_done = 1'b0;
    forever begin
      int dly;
      @(negedge clk);
      if (o_flag_tx_ready === 1'b1) begin
        dly = (resp_cnt == stall_at) ? 1005 : 5;
        if (resp_cnt == spur_at) begin
          #1 i_uart_tx_done = 1'b1;
          @(posedge clk);
          #1 i_uart_tx_done = 1'b0;
          dly--;
        end
        resp_cnt++;
        repeat (dly) @(posedge clk);
        #1 i_uart_tx_done = 1'b1;
        @(posedge clk);
        #1 i_uart_tx_done = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    cyc(1);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) cyc(1);
    chk(name, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic wait_frames(input string name, input int n, input int budget);
    for (int i = 0; i < budget && frame_cnt < n; i++) cyc(1);
    chk(name, 32'(frame_cnt >= n), 32'd1);
  endtask

  initial begin
    int d0;
    logic [7:0] first8 [8];
    first8 = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h2C, 8'h01, 8'h00, 8'h00};
    i_reset = 1'b1; i_start = 1'b0;
    i_mips_pc = 32'h0000_0040; i_clk_wiz_count = 32'h0000_012C;
    cyc(3);
    i_reset = 1'b0;
    cyc(2);
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_data", 32'(o_uart_tx_data), 32'd0);

    // Plain dump with literal pins on the stream and its timing.
    resp_cnt = 0;
    pulse_start();
    wait_done("dumpA_done_timeout", 4000);
    chk("dumpA_frames", 32'(frame_cnt), 32'd200);
    for (int i = 0; i < 8; i++) chk("dumpA_first8", 32'(frames_log[i]), 32'(first8[i]));
    chk("dumpA_r31_b0", 32'(frames_log[132]), 32'h1F);
    chk("dumpA_r31_b1", 32'(frames_log[133]), 32'h00);
    chk("dumpA_last_b0", 32'(frames_log[196]), 32'h0F);
    chk("dumpA_last_b1", 32'(frames_log[197]), 32'h01);
    chk("dumpA_last_b3", 32'(frames_log[199]), 32'h00);
    chk("gap_start", 32'(flag_cyc[0] - start_cyc), 32'd3);
    chk("gap_inword", 32'(flag_cyc[1] - flag_cyc[0]), 32'd6);
    chk("gap_word", 32'(flag_cyc[4] - flag_cyc[3]), 32'd9);
    cyc(3);
    chk("dumpA_regaddr_hold", 32'(o_select_addr_registers), 32'd31);
    chk("dumpA_memaddr_hold", o_select_addr_memdata, 32'd15);
    chk("dumpA_busy_low", 32'(o_busy), 32'd0);

    // Restart attempt mid-dump, spurious done in SEND, long UART stall.
    resp_cnt = 0; spur_at = 20; stall_at = 40;
    d0 = done_cnt;
    pulse_start();
    wait_frames("dumpB_reach10", 10, 2000);
    pulse_start();
    wait_done("dumpB_done_timeout", 6000);
    chk("dumpB_frames", 32'(frame_cnt), 32'd200);
    chk("dumpB_one_done", 32'(done_cnt - d0), 32'd1);
    spur_at = -1; stall_at = -1;
    cyc(3);

    // Reset during R5, then a fresh dump from PC with new PC/count values.
    i_mips_pc = 32'hDEAD_BEEF; i_clk_wiz_count = 32'h1234_5678;
    resp_cnt = 0;
    d0 = done_cnt;
    pulse_start();
    wait_frames("dumpC_reach30", 30, 2000);
    i_reset = 1'b1;
    cyc(1);
    i_reset = 1'b0;
    cyc(12);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_busy", 32'(o_busy), 32'd0);
    resp_cnt = 0;
    pulse_start();
    wait_done("dumpD_done_timeout", 4000);
    chk("dumpD_frames", 32'(frame_cnt), 32'd200);
    chk("dumpD_first", 32'(frames_log[0]), 32'hEF);
    chk("dumpD_cyc_b3", 32'(frames_log[7]), 32'h12);
    cyc(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got t=%0t expected finish earlier", $time);
    $fatal(1);
  end

endmodule
